pe_typeb_vec: RTL and testbench

PE_TYPEB_VEC -- requirements
Module: pe_typeb_vec

---
 rtl/pe_typeb_vec_pkg.sv | 32 +++
 rtl/pe_typeb_vec_i2d_lane.sv | 110 +++++++++++
 rtl/pe_typeb_vec.sv | 119 +++++++++++
 tb/tb_pe_typeb_vec.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_typeb_vec_pkg.sv
// pe_typeb_vec_pkg
// Shared definitions for the integer-to-double vector processing element:
// the per-beat operation encoding, IEEE-754 double field widths and a
// leading-zero counter used by every lane.
// No ports (package).
package pe_typeb_vec_pkg;

  localparam int DWIDTH_DOUBLE = 64;
  localparam int EXP_W         = 11;
  localparam int MANT_W        = 52;
  localparam int EXP_BIAS      = 1023;
  localparam int LZ_W          = 7;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_S2D  = 2'b01,
    OP_U2D  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Returns 63 - (index of the most significant set bit), or 64 for a zero
  // input. Scanning upward lets the highest set bit win.
  function automatic logic [LZ_W-1:0] lzc64(input logic [DWIDTH_DOUBLE-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(DWIDTH_DOUBLE);
    for (int i = 0; i < DWIDTH_DOUBLE; i++) begin
      if (v[i]) n = LZ_W'(DWIDTH_DOUBLE - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/pe_typeb_vec_i2d_lane.sv
// i2d_lane
// One 64-bit lane of the vector element. Over LATENCY register stages it
// either passes the word through or converts a signed/unsigned int64 to an
// IEEE-754 double (round to nearest, ties to even).
//   stage 1        : capture data and op
//   stage 1 -> 2   : sign/magnitude split and leading-zero count
//   stage 2 -> 3   : normalise shift, round, pack
//   stage 3 -> L   : plain delay so every op sees the same latency
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   in_data/in_op  word and operation entering stage 1 (every cycle)
//   out_data       result leaving stage LATENCY
module i2d_lane
  import pe_typeb_vec_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH_DOUBLE-1:0] in_data,
  input  op_e                      in_op,
  output logic [DWIDTH_DOUBLE-1:0] out_data
);

  localparam int MAG_W = EXP_W + MANT_W;
  localparam int G_BIT = DWIDTH_DOUBLE - 2 - MANT_W;

  logic [DWIDTH_DOUBLE-1:0] s1_data_q, s1_data_d;
  op_e                      s1_op_q, s1_op_d;

  logic [DWIDTH_DOUBLE-1:0] s2_abs_q, s2_abs_d;
  logic [DWIDTH_DOUBLE-1:0] s2_raw_q, s2_raw_d;
  logic [LZ_W-1:0]          s2_lz_q, s2_lz_d;
  logic                     s2_neg_q, s2_neg_d;
  logic                     s2_cvt_q, s2_cvt_d;

  logic [DWIDTH_DOUBLE-1:0] res_q [3:LATENCY];
  logic [DWIDTH_DOUBLE-1:0] res_d [3:LATENCY];

  logic [DWIDTH_DOUBLE-1:0] norm;
  logic [EXP_W-1:0]         exp_w;
  logic [MANT_W-1:0]        mant_w;
  logic                     guard_b;
  logic                     sticky_b;
  logic                     round_up;
  logic [MAG_W-1:0]         mag;

  always_comb begin
    s1_data_d = in_data;
    s1_op_d   = in_op;
  end

  // Signed conversion of the most negative value negates to itself, which is
  // exactly the magnitude 2^63 we want, so no special case is needed.
  always_comb begin
    s2_raw_d = s1_data_q;
    s2_cvt_d = (s1_op_q == OP_S2D) || (s1_op_q == OP_U2D);
    s2_neg_d = (s1_op_q == OP_S2D) && s1_data_q[DWIDTH_DOUBLE-1];
    s2_abs_d = s2_neg_d ? (~s1_data_q + 1'b1) : s1_data_q;
    s2_lz_d  = lzc64(s2_abs_d);
  end

  // After normalising, bit 63 is the hidden one. Adding the round bit to the
  // packed {exponent, mantissa} lets a mantissa overflow carry straight into
  // the exponent; the largest input only reaches exponent 1087, far from Inf.
  always_comb begin
    norm     = s2_abs_q << s2_lz_q;
    exp_w    = EXP_W'(EXP_BIAS + DWIDTH_DOUBLE - 1) - EXP_W'(s2_lz_q);
    mant_w   = norm[DWIDTH_DOUBLE-2 -: MANT_W];
    guard_b  = norm[G_BIT];
    sticky_b = |norm[G_BIT-1:0];
    round_up = guard_b && (sticky_b || mant_w[0]);
    mag      = {exp_w, mant_w} + MAG_W'(round_up);

    for (int k = 3; k <= LATENCY; k++) res_d[k] = res_q[k];
    if (!s2_cvt_q) begin
      res_d[3] = s2_raw_q;
    end else if (s2_abs_q == '0) begin
      res_d[3] = '0;
    end else begin
      res_d[3] = {s2_neg_q, mag};
    end
    for (int k = 4; k <= LATENCY; k++) res_d[k] = res_q[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data_q <= '0;
      s1_op_q   <= OP_PASS;
      s2_abs_q  <= '0;
      s2_raw_q  <= '0;
      s2_lz_q   <= '0;
      s2_neg_q  <= 1'b0;
      s2_cvt_q  <= 1'b0;
      for (int k = 3; k <= LATENCY; k++) res_q[k] <= '0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_op_q   <= s1_op_d;
      s2_abs_q  <= s2_abs_d;
      s2_raw_q  <= s2_raw_d;
      s2_lz_q   <= s2_lz_d;
      s2_neg_q  <= s2_neg_d;
      s2_cvt_q  <= s2_cvt_d;
      for (int k = 3; k <= LATENCY; k++) res_q[k] <= res_d[k];
    end
  end

  assign out_data = res_q[LATENCY];

endmodule

// File: rtl/pe_typeb_vec.sv
// pe_typeb_vec
// Vector integer-to-double element: LANES parallel 64-bit lanes share one
// AXI-stream style handshake. Accepted beats run through a fixed LATENCY
// pipeline that never stalls and land in a first-word-fall-through FIFO.
// Back-pressure is credit based: a beat is only accepted when the FIFO is
// guaranteed room for it and for everything already in the pipeline.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready    input beat handshake, op sampled with it
//   m_tdata/m_tvalid/m_tready    result beat handshake (FIFO head)
//   err_op                       sticky flag, set by any accepted reserved op
module pe_typeb_vec
  import pe_typeb_vec_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*64-1:0]      s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [1:0]               op,
  output logic [LANES*64-1:0]      m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     err_op
);

  localparam int DW = LANES * DWIDTH_DOUBLE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [LATENCY:1]   vld_q, vld_d;
  logic [DW-1:0]      mem_q [FIFO_DEPTH];
  logic [DW-1:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_op_q, err_op_d;

  logic [IW-1:0]      inflight;
  logic [DW-1:0]      lane_out;
  logic               accept;
  logic               fifo_wr;
  logic               fifo_rd;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      i2d_lane #(.LATENCY(LATENCY)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .in_data  (s_tdata[g*DWIDTH_DOUBLE +: DWIDTH_DOUBLE]),
        .in_op    (op_e'(op)),
        .out_data (lane_out[g*DWIDTH_DOUBLE +: DWIDTH_DOUBLE])
      );
    end
  endgenerate

  // Reset release is pulled through two flops so s_tready rises cleanly on
  // the clock rather than on the asynchronous reset edge.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Credits: every beat in the pipeline already owns a FIFO slot, so the
  // FIFO can never overflow even though the pipeline cannot stall.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= LATENCY; k++) inflight = inflight + IW'(vld_q[k]);
    s_tready = rst_sync_q[1] && ((int'(count_q) + int'(inflight)) < FIFO_DEPTH);
    accept   = s_tvalid && s_tready;
    m_tvalid = (count_q != '0);
    m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    err_op   = err_op_q;
  end

  // Pointers are PW bits wide, so they wrap modulo the power-of-two depth.
  always_comb begin
    vld_d    = {vld_q[LATENCY-1:1], accept};
    fifo_wr  = vld_q[LATENCY];
    fifo_rd  = m_tvalid && m_tready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = lane_out;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(fifo_wr) - CW'(fifo_rd);
    err_op_d = err_op_q || (accept && (op_e'(op) == OP_RSVD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_op_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_op_q   <= err_op_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_pe_typeb_vec.sv
// tb_pe_typeb_vec
// Directed bench for pe_typeb_vec. Stimulus pushes the hand-computed result
// of every accepted beat into a queue; a monitor pops and compares whenever
// the DUT hands over a result.
module tb_pe_typeb_vec;

  localparam int LANES      = 4;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int W          = LANES * 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [1:0]   s_op;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         err_op;

  logic [W-1:0] exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  pe_typeb_vec #(
    .LANES(LANES), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .op       (s_op),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .err_op   (err_op)
  );

  function automatic logic [W-1:0] pack4(input logic [63:0] l3, input logic [63:0] l2,
                                         input logic [63:0] l1, input logic [63:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Compare one value and log a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one beat, wait (bounded) for it to be accepted, record its result.
  task automatic applyStimulus(input logic [W-1:0] data, input logic [1:0] o, input logic [W-1:0] expv);
    int waited;
    s_tdata  = data;
    s_op     = o;
    s_tvalid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!s_tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_in_time", W'(s_tready), W'(1));
    if (s_tready) exp_q.push_back(expv);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput(name, W'(exp_q.size()), W'(0));
  endtask

  // Monitor: a transfer happens on the next rising edge when both are high.
  always @(negedge clk) begin
    if (rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_beat: got %0h, expected no result", m_tdata);
      end else begin
        checkOutput("result_beat", m_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int acc;
    logic [W-1:0] beat;

    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_op     = 2'b00;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_m_tvalid", W'(m_tvalid), W'(0));
    checkOutput("rst_s_tready", W'(s_tready), W'(0));
    checkOutput("rst_err_op",   W'(err_op),   W'(0));
    checkOutput("rst_m_tdata",  m_tdata,      W'(0));
    rst = 1'b1;
    cyc = 0;
    while (!s_tready && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("ready_after_reset", W'(s_tready), W'(1));

    $display("[TB] signed conversion and cold-start latency");
    applyStimulus(pack4(64'd0, 64'h0020000000000001, 64'hFFFFFFFFFFFFFFFF, 64'd1), 2'b01,
                  pack4(64'h0, 64'h4340000000000000, 64'hBFF0000000000000, 64'h3FF0000000000000));
    s_tvalid = 1'b0;
    cyc = 0;
    while (!m_tvalid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("cold_latency", W'(cyc), W'(LATENCY));
    waitDrain("drain_signed");

    $display("[TB] extremes and rounding");
    applyStimulus({4{64'hFFFFFFFFFFFFFFFF}}, 2'b10, {4{64'h43F0000000000000}});
    applyStimulus({4{64'h8000000000000000}}, 2'b01, {4{64'hC3E0000000000000}});
    applyStimulus(pack4(64'h0020000000000003, 64'hFFFFFFFFFFFFFFFB, 64'h7FFFFFFFFFFFFFFF, 64'd1), 2'b01,
                  pack4(64'h4340000000000002, 64'hC014000000000000, 64'h43E0000000000000, 64'h3FF0000000000000));
    applyStimulus(pack4(64'd0, 64'd1, 64'h8000000000000000, 64'd5), 2'b10,
                  pack4(64'h0, 64'h3FF0000000000000, 64'h43E0000000000000, 64'h4014000000000000));
    s_tvalid = 1'b0;
    waitDrain("drain_extremes");

    $display("[TB] alternating op");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyStimulus({4{64'd5}}, 2'b00, {4{64'd5}});
      else            applyStimulus({4{64'd5}}, 2'b01, {4{64'h4014000000000000}});
    end
    s_tvalid = 1'b0;
    waitDrain("drain_alternate");

    $display("[TB] reserved op");
    checkOutput("err_op_before", W'(err_op), W'(0));
    applyStimulus(pack4(64'hDEADBEEF, 64'h12345678, 64'hFFFFFFFFFFFFFFFF, 64'h1),
                  2'b11, pack4(64'hDEADBEEF, 64'h12345678, 64'hFFFFFFFFFFFFFFFF, 64'h1));
    s_tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("err_op_set", W'(err_op), W'(1));
    applyStimulus({4{64'd7}}, 2'b00, {4{64'd7}});
    s_tvalid = 1'b0;
    waitDrain("drain_reserved");
    checkOutput("err_op_sticky", W'(err_op), W'(1));

    $display("[TB] back-pressure");
    m_tready = 1'b0;
    acc = 0;
    s_tvalid = 1'b1;
    s_op = 2'b00;
    for (int c = 0; c < 20; c++) begin
      beat = pack4(64'(acc * 4 + 3), 64'(acc * 4 + 2), 64'(acc * 4 + 1), 64'(acc * 4));
      s_tdata = beat;
      @(negedge clk);
      if (s_tready) begin
        exp_q.push_back(beat);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    checkOutput("bp_accepted", W'(acc), W'(FIFO_DEPTH));
    checkOutput("bp_ready_low", W'(s_tready), W'(0));
    checkOutput("bp_head_hold1", m_tdata, pack4(64'd3, 64'd2, 64'd1, 64'd0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_head_hold2", m_tdata, pack4(64'd3, 64'd2, 64'd1, 64'd0));
    m_tready = 1'b1;
    waitDrain("drain_backpressure");

    $display("[TB] reset mid-operation");
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus({4{64'(100 + i)}}, 2'b11, {4{64'(100 + i)}});
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_reset_valid", W'(m_tvalid), W'(1));
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_m_tvalid", W'(m_tvalid), W'(0));
    checkOutput("mid_rst_m_tdata",  m_tdata,      W'(0));
    checkOutput("mid_rst_s_tready", W'(s_tready), W'(0));
    checkOutput("mid_rst_err_op",   W'(err_op),   W'(0));
    exp_q.delete();
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_stale_valid", W'(m_tvalid), W'(0));
    checkOutput("err_op_after_reset", W'(err_op), W'(0));
    applyStimulus({4{64'd1}}, 2'b01, {4{64'h3FF0000000000000}});
    s_tvalid = 1'b0;
    waitDrain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
